// File: rtl/mem_bus_controller_pkg.sv
// mem_bus_controller_pkg: FSM states, default region indices and wait-field width.
package mem_bus_controller_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_STROBE, ST_WAIT, ST_DONE} state_e;
  localparam int RGN_DRAM = 0;
  localparam int RGN_VGA  = 1;
  localparam int RGN_IO   = 3;
  localparam int WAIT_W   = 8;
endpackage

// File: rtl/mem_bus_controller_wait_counter.sv
// wait_counter: loadable 8-bit down counter that saturates at zero and flags the last wait cycle.
module wait_counter
  import mem_bus_controller_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              dec,
  input  logic [WAIT_W-1:0] load_val,
  output logic              last
);
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (dec && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  assign last = cnt_q == WAIT_W'(1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/mem_bus_controller.sv
// mem_bus_controller: registered region decoder with per-region wait states and a req/ready/ack CPU handshake.
module mem_bus_controller
  import mem_bus_controller_pkg::*;
#(
  parameter int                   WIDTH    = 32,
  parameter int                   ADDR_W   = 16,
  parameter int                   SEL_W    = 2,
  parameter int                   NREG     = 4,
  parameter logic [NREG-1:0]      MAP_MASK = 4'b1011,
  parameter logic [NREG*8-1:0]    WAITS    = 32'h00020100
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [WIDTH-1:0]        cpu_wdata,
  output logic                    cpu_ready,
  output logic                    cpu_ack,
  output logic [WIDTH-1:0]        cpu_rdata,
  output logic                    cpu_err,
  output logic [ADDR_W-SEL_W-1:0] reg_addr,
  output logic [WIDTH-1:0]        reg_wdata,
  output logic [NREG-1:0]         reg_wr_en,
  output logic [NREG-1:0]         reg_rd_en,
  input  logic [NREG*WIDTH-1:0]   reg_rdata
);
  localparam int OFF_W = ADDR_W - SEL_W;
  state_e             state_q, state_d;
  logic [SEL_W-1:0]   rgn_q, rgn_d;
  logic               we_q, we_d, ack_q, ack_d, err_q, err_d;
  logic [OFF_W-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [NREG-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic               load, dec, last, mapped, new_mapped;
  logic [SEL_W-1:0]   sel;
  logic [WAIT_W-1:0]  waits_r;
  assign sel        = cpu_addr[ADDR_W-1 -: SEL_W];
  assign new_mapped = MAP_MASK[sel];
  assign mapped     = MAP_MASK[rgn_q];
  assign waits_r    = WAITS[int'(rgn_q)*WAIT_W +: WAIT_W];
  wait_counter u_wait (.clk(clk), .reset(reset), .load(load), .dec(dec), .load_val(waits_r), .last(last));
  always_comb begin
    state_d = state_q;
    rgn_d   = rgn_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wr_d    = '0;
    rd_d    = '0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    load    = 1'b0;
    dec     = 1'b0;
    case (state_q)
      ST_IDLE: if (cpu_req) begin
        state_d = ST_STROBE;
        rgn_d   = sel;
        we_d    = cpu_we;
        addr_d  = cpu_addr[OFF_W-1:0];
        wdata_d = cpu_wdata;
        wr_d    = (new_mapped && cpu_we) ? NREG'(1) << sel : '0;
        rd_d    = (new_mapped && !cpu_we) ? NREG'(1) << sel : '0;
      end
      ST_STROBE: begin
        load    = mapped;
        state_d = (!mapped || waits_r == '0) ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        dec     = 1'b1;
        state_d = last ? ST_DONE : ST_WAIT;
      end
      default: begin
        state_d = ST_IDLE;
        ack_d   = 1'b1;
        err_d   = !mapped;
        rdata_d = !mapped ? '0 : we_q ? rdata_q : reg_rdata[int'(rgn_q)*WIDTH +: WIDTH];
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= ST_IDLE;
      rgn_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rgn_q   <= rgn_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  assign cpu_ready = state_q == ST_IDLE;
  assign cpu_ack   = ack_q;
  assign cpu_err   = err_q;
  assign cpu_rdata = rdata_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_wr_en = wr_q;
  assign reg_rd_en = rd_q;
endmodule

// File: tb/tb_mem_bus_controller.sv
// tb_mem_bus_controller: directed and random accesses on a default and a slow-r3 controller against a latency/data model.
module tb_mem_bus_controller;
  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        req;
  logic              we;
  logic [15:0]       addr;
  logic [31:0]       wdata;
  logic [127:0]      rdata_in;
  logic [1:0]        ready, ack, err;
  logic [1:0][31:0]  rdata, rwd;
  logic [1:0][13:0]  raddr;
  logic [1:0][3:0]   wen, ren;
  logic [1:0][31:0]  hold;
  int total = 0;
  int passed = 0;
  always #5 clk = ~clk;

  mem_bus_controller dut0 (
    .clk(clk), .reset(reset), .cpu_req(req[0]), .cpu_we(we), .cpu_addr(addr), .cpu_wdata(wdata),
    .cpu_ready(ready[0]), .cpu_ack(ack[0]), .cpu_rdata(rdata[0]), .cpu_err(err[0]),
    .reg_addr(raddr[0]), .reg_wdata(rwd[0]), .reg_wr_en(wen[0]), .reg_rd_en(ren[0]), .reg_rdata(rdata_in));

  mem_bus_controller #(.WAITS(32'hFF000000)) dut1 (
    .clk(clk), .reset(reset), .cpu_req(req[1]), .cpu_we(we), .cpu_addr(addr), .cpu_wdata(wdata),
    .cpu_ready(ready[1]), .cpu_ack(ack[1]), .cpu_rdata(rdata[1]), .cpu_err(err[1]),
    .reg_addr(raddr[1]), .reg_wdata(rwd[1]), .reg_wr_en(wen[1]), .reg_rd_en(ren[1]), .reg_rdata(rdata_in));

  function automatic int waits_of(int i, int r);
    if (i == 0) return (r == 1) ? 1 : (r == 2) ? 2 : 0;
    return (r == 3) ? 255 : 0;
  endfunction

  function automatic bit is_mapped(int r);
    return r != 2;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_idle(int i);
    chk("rst_ready", ready[i], 1);
    chk("rst_ack", ack[i], 0);
    chk("rst_err", err[i], 0);
    chk("rst_rdata", rdata[i], 0);
    chk("rst_raddr", raddr[i], 0);
    chk("rst_rwdata", rwd[i], 0);
    chk("rst_wen", wen[i], 0);
    chk("rst_ren", ren[i], 0);
  endtask

  // Called at a negedge; returns at the negedge of the ack cycle.
  task automatic access(int i, bit wr, logic [15:0] a, logic [31:0] wd, bit hold_req);
    int r = int'(a[15:14]);
    int lat = is_mapped(r) ? 2 + waits_of(i, r) : 2;
    logic [3:0] oh = is_mapped(r) ? 4'(1 << r) : 4'h0;
    logic [31:0] exp_rd = !is_mapped(r) ? 32'h0 : wr ? hold[i] : rdata_in[r*32 +: 32];
    we = wr;
    addr = a;
    wdata = wd;
    req[i] = 1'b1;
    chk("ready_pre", ready[i], 1);
    @(posedge clk);
    for (int d = 0; d <= lat; d++) begin
      @(negedge clk);
      if (d == 0 && !hold_req) begin
        req[i] = 1'b0;
        we = 1'($urandom_range(1));
        addr = 16'($urandom);
        wdata = $urandom;
      end
      chk("wr_en", wen[i], (d == 0 && wr) ? oh : 4'h0);
      chk("rd_en", ren[i], (d == 0 && !wr) ? oh : 4'h0);
      chk("ready", ready[i], d == lat);
      chk("ack", ack[i], d == lat);
      chk("err", err[i], d == lat && !is_mapped(r));
      if (d < lat) begin
        chk("reg_addr", raddr[i], a[13:0]);
        chk("reg_wdata", rwd[i], wd);
      end
    end
    chk("rdata", rdata[i], exp_rd);
    hold[i] = exp_rd;
  endtask

  initial begin
    int acks;
    reset = 1'b1;
    req = 2'b00;
    we = 1'b0;
    addr = '0;
    wdata = '0;
    rdata_in = {$urandom, $urandom, $urandom, $urandom};
    hold = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle(0);
    chk_idle(1);
    reset = 1'b0;
    @(negedge clk);
    rdata_in[31:0] = 32'hDEADBEEF;
    access(0, 1'b0, 16'h0010, 32'h0, 1'b0);
    access(0, 1'b1, 16'h4005, 32'h0000007F, 1'b0);
    access(0, 1'b0, 16'h8000, 32'h0, 1'b0);
    rdata_in = {$urandom, $urandom, $urandom, $urandom};
    access(0, 1'b1, 16'hC002, 32'h00001234, 1'b1);
    access(0, 1'b0, 16'h0003, 32'h0, 1'b0);
    for (int n = 0; n < 40; n++) begin
      rdata_in = {$urandom, $urandom, $urandom, $urandom};
      access(0, 1'($urandom_range(1)), 16'($urandom), $urandom, 1'($urandom_range(1)));
    end
    rdata_in[127:96] = 32'hCAFEF00D;
    access(1, 1'b0, 16'hC001, 32'h0, 1'b0);
    we = 1'b0;
    addr = 16'hC001;
    req[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req[1] = 1'b0;
    chk("r5_rd_en", ren[1], 4'h8);
    repeat (20) @(posedge clk);
    #2 reset = 1'b1;
    #1 chk_idle(1);
    @(negedge clk);
    reset = 1'b0;
    hold = '0;
    acks = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      acks += int'(ack[1]);
    end
    chk("r5_no_ack", acks, 0);
    chk("r5_ready", ready[1], 1);
    rdata_in[31:0] = 32'h0BADF00D;
    access(1, 1'b0, 16'h0008, 32'h0, 1'b0);
    access(1, 1'b1, 16'hC00A, 32'h55AA55AA, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
